// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-side and mul/div unit signals of the mul/div sequencing controller
interface muldiv_ctrl_if;
  logic        op_valid_i;
  logic [2:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] hilo_i;
  logic        flush_i;
  logic        mul_start_o;
  logic        mul_signed_o;
  logic [31:0] mul_op1_o;
  logic [31:0] mul_op2_o;
  logic [63:0] mul_result_i;
  logic        mul_ready_i;
  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic        div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o;
  logic [63:0] result_o;
  logic        result_valid_o;

  modport master (
    input  op_valid_i, op_i, opdata1_i, opdata2_i, hilo_i, flush_i,
    input  mul_result_i, mul_ready_i, div_result_i, div_ready_i,
    output mul_start_o, mul_signed_o, mul_op1_o, mul_op2_o,
    output div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o,
    output stallreq_o, result_o, result_valid_o
  );

  modport slave (
    output op_valid_i, op_i, opdata1_i, opdata2_i, hilo_i, flush_i,
    output mul_result_i, mul_ready_i, div_result_i, div_ready_i,
    input  mul_start_o, mul_signed_o, mul_op1_o, mul_op2_o,
    input  div_start_o, div_signed_o, div_op1_o, div_op2_o, div_annul_o,
    input  stallreq_o, result_o, result_valid_o
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - sequences one mul/div/madd/msub op at a time onto the shared multiplier and divider
module muldiv_ctrl (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_BUSY,
    S_ACCUM,
    S_DIV_BUSY,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [63:0] hilo_q;
  logic [63:0] prod_q;
  logic [63:0] result_q;
  logic        mul_start_q;
  logic        div_start_q;
  logic        annul_q;
  logic        valid_q;
  logic [63:0] accum_d;

  // op_q[1] separates MSUB* from MADD* within the accumulate class
  assign accum_d = op_q[1] ? (hilo_q - prod_q) : (hilo_q + prod_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      hilo_q      <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      annul_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      annul_q <= 1'b0;
      valid_q <= 1'b0;
      if (bus.flush_i) begin
        result_q <= '0;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.op_valid_i && !bus.flush_i) begin
            op_q   <= bus.op_i;
            opa_q  <= bus.opdata1_i;
            opb_q  <= bus.opdata2_i;
            hilo_q <= bus.hilo_i;
            if (bus.op_i[2] || !bus.op_i[1]) begin
              mul_start_q <= 1'b1;
              state_q     <= S_MUL_BUSY;
            end else if (bus.opdata2_i == 32'd0) begin
              result_q <= '0;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              div_start_q <= 1'b1;
              state_q     <= S_DIV_BUSY;
            end
          end
        end
        S_MUL_BUSY: begin
          if (bus.mul_ready_i) begin
            mul_start_q <= 1'b0;
            if (bus.flush_i) begin
              state_q <= S_IDLE;
            end else if (op_q[2]) begin
              prod_q  <= bus.mul_result_i;
              state_q <= S_ACCUM;
            end else begin
              result_q <= bus.mul_result_i;
              valid_q  <= 1'b1;
              state_q  <= S_DONE;
            end
          end else if (bus.flush_i) begin
            // the multiplier counter only clears on completion, so start stays held
            state_q <= S_DRAIN;
          end
        end
        S_ACCUM: begin
          if (bus.flush_i) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= accum_d;
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DIV_BUSY: begin
          if (bus.flush_i) begin
            div_start_q <= 1'b0;
            annul_q     <= 1'b1;
            state_q     <= S_IDLE;
          end else if (bus.div_ready_i) begin
            div_start_q <= 1'b0;
            result_q    <= bus.div_result_i;
            valid_q     <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus.mul_ready_i) begin
            mul_start_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mul_start_o  = mul_start_q;
  assign bus.mul_signed_o = mul_start_q & ~op_q[0];
  assign bus.mul_op1_o    = opa_q;
  assign bus.mul_op2_o    = opb_q;
  assign bus.div_start_o  = div_start_q;
  assign bus.div_signed_o = div_start_q & ~op_q[0];
  assign bus.div_op1_o    = opa_q;
  assign bus.div_op2_o    = opb_q;
  assign bus.div_annul_o  = annul_q;
  assign bus.result_o     = result_q;
  // a flush arriving in the DONE cycle must still be able to kill the strobe
  assign bus.result_valid_o = valid_q & ~bus.flush_i;

  always_comb begin
    bus.stallreq_o = 1'b0;
    case (state_q)
      S_IDLE, S_DRAIN:                  bus.stallreq_o = bus.op_valid_i & ~bus.flush_i;
      S_MUL_BUSY, S_ACCUM, S_DIV_BUSY:  bus.stallreq_o = 1'b1;
      default:                          bus.stallreq_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed bench for muldiv_ctrl with 6-cycle multiplier and 4-cycle divider models
module tb_muldiv_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   mcnt;
  int   dcnt;
  logic div_seen;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // multiplier: ready on the 6th cycle of start
  assign bus.mul_ready_i = bus.mul_start_o && (mcnt == 5);
  always_comb begin
    logic [63:0] sa;
    logic [63:0] sb;
    sa = {{32{bus.mul_op1_o[31]}}, bus.mul_op1_o};
    sb = {{32{bus.mul_op2_o[31]}}, bus.mul_op2_o};
    if (bus.mul_signed_o) bus.mul_result_i = sa * sb;
    else                  bus.mul_result_i = {32'd0, bus.mul_op1_o} * {32'd0, bus.mul_op2_o};
  end
  always @(posedge clk) begin
    if (rst || !bus.mul_start_o || bus.mul_ready_i) mcnt <= 0;
    else                                            mcnt <= mcnt + 1;
  end

  // divider: ready on the 4th cycle of start
  assign bus.div_ready_i = bus.div_start_o && (dcnt == 3);
  always_comb begin
    logic signed [31:0] q;
    logic signed [31:0] r;
    q = '0;
    r = '0;
    if (bus.div_op2_o != 32'd0) begin
      if (bus.div_signed_o) begin
        q = $signed(bus.div_op1_o) / $signed(bus.div_op2_o);
        r = $signed(bus.div_op1_o) % $signed(bus.div_op2_o);
      end else begin
        q = bus.div_op1_o / bus.div_op2_o;
        r = bus.div_op1_o % bus.div_op2_o;
      end
    end
    bus.div_result_i = {r, q};
  end
  always @(posedge clk) begin
    if (rst || !bus.div_start_o || bus.div_ready_i || bus.div_annul_o) dcnt <= 0;
    else                                                               dcnt <= dcnt + 1;
  end

  always @(posedge clk) if (bus.div_start_o) div_seen = 1'b1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] h,
                       input logic [63:0] exp_res, input int exp_lat);
    int n;
    bus.op_valid_i = 1'b1;
    bus.op_i       = op;
    bus.opdata1_i  = a;
    bus.opdata2_i  = b;
    bus.hilo_i     = h;
    #1;
    chk({tag, "_stall_accept"}, 64'(bus.stallreq_o), 64'd1);
    cyc();
    bus.op_valid_i = 1'b0;
    n = 1;
    #1;
    while (!bus.result_valid_o && n < 30) begin
      chk({tag, "_stall_busy"}, 64'(bus.stallreq_o), 64'd1);
      chk({tag, "_excl_start"}, 64'(bus.mul_start_o & bus.div_start_o), 64'd0);
      cyc();
      #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_result"}, bus.result_o, exp_res);
    chk({tag, "_stall_done"}, 64'(bus.stallreq_o), 64'd0);
    cyc();
    #1;
    chk({tag, "_strobe_once"}, 64'(bus.result_valid_o), 64'd0);
    chk({tag, "_result_hold"}, bus.result_o, exp_res);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    div_seen = 1'b0;
    rst = 1'b1;
    bus.op_valid_i = 1'b0;
    bus.op_i       = '0;
    bus.opdata1_i  = '0;
    bus.opdata2_i  = '0;
    bus.hilo_i     = '0;
    bus.flush_i    = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_mul_start", 64'(bus.mul_start_o), 64'd0);
    chk("rst_div_start", 64'(bus.div_start_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_valid", 64'(bus.result_valid_o), 64'd0);
    chk("rst_stall", 64'(bus.stallreq_o), 64'd0);
    cyc();

    do_op("mult",  3'b000, 32'hFFFFFFFE, 32'd3, 64'd0, 64'hFFFFFFFF_FFFFFFFA, 7);
    do_op("multu", 3'b001, 32'hFFFFFFFE, 32'd3, 64'd0, 64'h00000002_FFFFFFFA, 7);
    do_op("madd",  3'b100, 32'd4, 32'd5, 64'h10, 64'h24, 8);
    do_op("msubu", 3'b111, 32'd1, 32'd1, 64'd0, 64'hFFFFFFFF_FFFFFFFF, 8);

    div_seen = 1'b0;
    do_op("div", 3'b010, 32'hFFFFFFF9, 32'd2, 64'd0, 64'hFFFFFFFF_FFFFFFFD, 5);
    chk("div_start_seen", 64'(div_seen), 64'd1);
    div_seen = 1'b0;
    do_op("divu_zero", 3'b011, 32'd9, 32'd0, 64'd0, 64'd0, 1);
    chk("divu_zero_no_start", 64'(div_seen), 64'd0);

    // flush at T+3 of a MULT, second op waiting from T+4
    bus.op_valid_i = 1'b1;
    bus.op_i       = 3'b000;
    bus.opdata1_i  = 32'd5;
    bus.opdata2_i  = 32'd7;
    #1;
    cyc();
    bus.op_valid_i = 1'b0;
    cyc();
    cyc();
    bus.flush_i = 1'b1;
    #1;
    chk("fl_mul_start_t3", 64'(bus.mul_start_o), 64'd1);
    cyc();
    bus.flush_i    = 1'b0;
    bus.op_valid_i = 1'b1;
    bus.op_i       = 3'b001;
    bus.opdata1_i  = 32'd3;
    bus.opdata2_i  = 32'd4;
    #1;
    chk("fl_result_cleared", bus.result_o, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("fl_drain_stall", 64'(bus.stallreq_o), 64'd1);
      chk("fl_drain_start", 64'(bus.mul_start_o), 64'd1);
      chk("fl_drain_op1", 64'(bus.mul_op1_o), 64'd5);
      chk("fl_drain_valid", 64'(bus.result_valid_o), 64'd0);
      cyc();
      #1;
    end
    chk("fl_drained_start", 64'(bus.mul_start_o), 64'd0);
    chk("fl_drained_valid", 64'(bus.result_valid_o), 64'd0);
    do_op("multu_after_drain", 3'b001, 32'd3, 32'd4, 64'd0, 64'd12, 7);

    // flush in DIV_BUSY
    bus.op_valid_i = 1'b1;
    bus.op_i       = 3'b011;
    bus.opdata1_i  = 32'd100;
    bus.opdata2_i  = 32'd7;
    #1;
    cyc();
    bus.op_valid_i = 1'b0;
    #1;
    chk("fd_div_start", 64'(bus.div_start_o), 64'd1);
    cyc();
    bus.flush_i = 1'b1;
    #1;
    cyc();
    bus.flush_i = 1'b0;
    #1;
    chk("fd_annul", 64'(bus.div_annul_o), 64'd1);
    chk("fd_start_drop", 64'(bus.div_start_o), 64'd0);
    chk("fd_result_cleared", bus.result_o, 64'd0);
    cyc();
    #1;
    chk("fd_annul_once", 64'(bus.div_annul_o), 64'd0);
    chk("fd_no_valid", 64'(bus.result_valid_o), 64'd0);

    // flush coincident with DONE
    bus.op_valid_i = 1'b1;
    bus.op_i       = 3'b011;
    bus.opdata1_i  = 32'd1;
    bus.opdata2_i  = 32'd0;
    #1;
    cyc();
    bus.op_valid_i = 1'b0;
    bus.flush_i    = 1'b1;
    #1;
    chk("fdone_valid", 64'(bus.result_valid_o), 64'd0);
    chk("fdone_stall", 64'(bus.stallreq_o), 64'd0);
    cyc();
    bus.flush_i = 1'b0;
    #1;
    chk("fdone_after_valid", 64'(bus.result_valid_o), 64'd0);
    cyc();

    do_op("mult_prime", 3'b000, 32'd6, 32'd7, 64'd0, 64'd42, 7);

    // reset at T+2 of a MADD
    bus.op_valid_i = 1'b1;
    bus.op_i       = 3'b100;
    bus.opdata1_i  = 32'd2;
    bus.opdata2_i  = 32'd3;
    bus.hilo_i     = 64'h55;
    #1;
    cyc();
    bus.op_valid_i = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mrst_mul_start", 64'(bus.mul_start_o), 64'd0);
    chk("mrst_op1", 64'(bus.mul_op1_o), 64'd0);
    chk("mrst_result", bus.result_o, 64'd0);
    chk("mrst_valid", 64'(bus.result_valid_o), 64'd0);
    chk("mrst_stall", 64'(bus.stallreq_o), 64'd0);
    chk("mrst_annul", 64'(bus.div_annul_o), 64'd0);
    do_op("mult_after_rst", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'd1, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
